// File: rtl/pwm_duty_ramp_sequencer.sv
// PWM duty ramp sequencer: walks duty_out toward a latched target in fixed steps every P+1 clocks.
// Define PWM_FADE_LOOP_EN to add loop_mode (continuous fade target <-> 0 until abort or reset).
module pwm_duty_ramp_sequencer #(
    parameter int DUTY_W   = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic                abort,
    input  logic [DUTY_W-1:0]   target_duty,
    input  logic [DUTY_W-1:0]   step_size,
    input  logic [PERIOD_W-1:0] step_period,
`ifdef PWM_FADE_LOOP_EN
    input  logic                loop_mode,
`endif
    output logic [DUTY_W-1:0]   duty_out,
    output logic                duty_wr,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
    localparam logic [DUTY_W-1:0]   STEP_ONE = DUTY_W'(1);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [DUTY_W-1:0]   step_q, step_d;
    logic [DUTY_W-1:0]   goal_q, goal_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                wr_q, wr_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
`ifdef PWM_FADE_LOOP_EN
    logic [DUTY_W-1:0]   tgt_q, tgt_d;
    logic                loop_q, loop_d;
`endif

    logic [DUTY_W:0]     up_sum;
    logic [DUTY_W:0]     dn_diff;
    logic [DUTY_W-1:0]   ramp_duty;
    logic [PERIOD_W-1:0] per_eff;
    logic [DUTY_W-1:0]   step_eff;

    assign per_eff  = (step_period == '0) ? CNT_ONE : step_period;
    assign step_eff = (step_size == '0) ? STEP_ONE : step_size;

    // One extra bit catches carry/borrow so the step clamps at the goal instead of wrapping.
    always_comb begin
        up_sum    = {1'b0, duty_q} + {1'b0, step_q};
        dn_diff   = {1'b0, duty_q} - {1'b0, step_q};
        ramp_duty = goal_q;
        if (goal_q > duty_q) begin
            if (up_sum < {1'b0, goal_q}) ramp_duty = up_sum[DUTY_W-1:0];
        end else if (!dn_diff[DUTY_W] && (dn_diff > {1'b0, goal_q})) begin
            ramp_duty = dn_diff[DUTY_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        step_d  = step_q;
        goal_d  = goal_q;
        duty_d  = duty_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        // busy lags the state by one clock, so it drops the cycle after done pulses.
        busy_d  = (state_q != S_IDLE);
`ifdef PWM_FADE_LOOP_EN
        tgt_d   = tgt_q;
        loop_d  = loop_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort && en) begin
                    goal_d  = target_duty;
                    step_d  = step_eff;
                    per_d   = per_eff;
                    cnt_d   = per_eff;
`ifdef PWM_FADE_LOOP_EN
                    tgt_d   = target_duty;
                    loop_d  = loop_mode;
`endif
                    state_d = (target_duty == duty_q) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (en) begin
                    if (cnt_q <= CNT_ONE) state_d = S_STEP;
                    else                  cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_STEP: begin
                // The update commits even when abort arrives in this cycle.
                duty_d = ramp_duty;
                wr_d   = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ramp_duty == goal_q) begin
`ifdef PWM_FADE_LOOP_EN
                    if (loop_q && (tgt_q != '0)) begin
                        goal_d  = (goal_q == '0) ? tgt_q : '0;
                        cnt_d   = per_q;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d   = per_q;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                done_d  = !abort;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            step_q  <= '0;
            goal_q  <= '0;
            duty_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PWM_FADE_LOOP_EN
            tgt_q   <= '0;
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            step_q  <= step_d;
            goal_q  <= goal_d;
            duty_q  <= duty_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef PWM_FADE_LOOP_EN
            tgt_q   <= tgt_d;
            loop_q  <= loop_d;
`endif
        end
    end

    assign duty_out  = duty_q;
    assign duty_wr   = wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/pwm_duty_ramp_sequencer.md
Name: pwm_duty_ramp_sequencer

Overview:
- Sequences the duty-cycle register of the project's PWM peripheral: ramps the applied duty from its current value to a commanded target in fixed steps at a programmable step interval.
- Sits between the SPI-written control registers (target, step, interval, start) and the PWM generator's duty input.
- Issues one write strobe per duty update, so the PWM block latches new values only at defined instants.

Parameters:
- DUTY_W, 8, width of duty values (target, step, output).
- PERIOD_W, 16, width of the step-interval counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  global enable (tied to design-select); when low, the interval counter freezes.
- start  in  1  single-cycle request to begin a ramp; sampled only in IDLE.
- abort  in  1  terminates any ramp; level-sensitive.
- target_duty  in  DUTY_W  destination duty; latched on an accepted start.
- step_size  in  DUTY_W  increment per step; latched on start; 0 is treated as 1.
- step_period  in  PERIOD_W  clocks between steps; latched on start; 0 is treated as 1.
- duty_out  out  DUTY_W  currently applied duty, to the PWM.
- duty_wr  out  1  one-cycle strobe in the same cycle duty_out changes.
- busy  out  1  high while a ramp is in progress.
- done  out  1  one-cycle pulse on ramp completion.

Behaviour:
- Reset (asynchronous, on rst high):
  - duty_out=0, duty_wr=0, busy=0, done=0.
  - State is IDLE; counter and latched registers are 0.
- States: IDLE, WAIT, STEP, DONE.
- IDLE:
  - start=1 and abort=0 and en=1: latch target, step (min 1) and period P=max(step_period,1); load counter=P; busy=1 from the next cycle.
  - If the latched target equals duty_out, go directly to DONE (no duty_wr). Otherwise go to WAIT.
- WAIT:
  - Each cycle with en=1, counter decrements. With en=0, the counter holds.
  - Counter reaching 1 with en=1 → STEP.
- STEP (one cycle):
  - Compute the new duty in DUTY_W+1 bits.
  - Ramp up: duty + step, saturated to target.
  - Ramp down: duty − step, floored to target.
  - No overshoot and no wrap-around at 0 or 2^DUTY_W−1.
  - duty_out updates at the end of the STEP cycle, and duty_wr is high for exactly that cycle.
  - New duty equals target → DONE. Otherwise reload counter=P and return to WAIT.
- DONE (one cycle): done=1, busy=0 from the next cycle, → IDLE.
- Timing:
  - The first duty_wr occurs P+1 cycles after start is sampled; later writes follow every P+1 cycles.
  - done follows the final duty_wr by exactly one cycle.
- start while busy: ignored; latched values are unchanged.
- abort:
  - From any non-IDLE state: → IDLE next cycle; duty_out holds its last value; no duty_wr, no done.
  - abort and start together in IDLE: abort wins and start is dropped.
  - abort during STEP: the STEP update still completes that cycle, then the block goes IDLE.
- en=0 in STEP or DONE: that state still completes; only WAIT counting freezes.
- Target register changes mid-ramp: no effect until the next accepted start.

Optional Feature:
- Macro PWM_FADE_LOOP_EN.
- Defined:
  - Adds input port loop_mode (1 bit), latched on start.
  - When latched loop_mode=1, reaching the target does not go to DONE. Instead the direction reverses toward 0, then back toward the target, indefinitely, with the same step and P (breathing effect).
  - done never pulses in loop mode; only abort or rst ends it.
  - If the target is 0, the block behaves as a single ramp.
- Undefined: port absent; single-ramp behaviour only.

Test Plan:
- Assert rst mid-ramp (duty_out=8) → all outputs 0 asynchronously, before the next clk edge; after release the block is IDLE and busy=0.
- From duty 0: target=10, step=4, period=3, start → duty_wr with duty_out 4, 8, 10 at cycles 4, 8, 12 after start; done at 13; busy low at 14.
- From duty 10: target=1, step=4, period=0 → duty 6, 2, 1 (floored, no wrap), written every 2 cycles; done one cycle after the write of 1.
- Ramp 0→200, step 50, period 5; abort after the second write → duty_out stays 100, no done; start during the ramp (before abort) is ignored.
- Ramp 0→20, step 5, period 4; hold en=0 for 7 cycles during WAIT → the write schedule shifts by exactly 7 cycles. Start with target equal to duty_out → done 1 cycle later, no duty_wr.
- PWM_FADE_LOOP_EN, loop_mode=1, target=6, step=3, period=1 → duty sequence 3, 6, 3, 0, 3, 6…; no done; abort stops the sequence with duty_out held.
